dmem_responder: RTL

- Multi-cycle data-memory responder serving the MEM-stage load/store requests of the pipelined MIPS core.
- Holds the data array and inserts a programmable number of wait states.
- Drives a stall to the core; the core's pipeline-register Write enables equal ~stall, freezing every stage while an access is outstanding.
- The MEM-stage request lines stay stable while stall is high.

---
 rtl/dmem_responder.sv | 117 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: holds the data array,
// inserts WAIT wait states per access and stalls the core while an access is outstanding.
module dmem_responder #(
    parameter int ADDR_W = 5,
    parameter int WAIT   = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              resp,
    output logic [CNT_W-1:0]  access_cnt
);

    localparam int unsigned      DEPTH   = 2 ** ADDR_W;
    localparam logic [3:0]       WAIT_LD = 4'(WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic              lat_wr;
    logic              req;
    logic              commit;
    logic [31:0]       mem [DEPTH];

    assign req = req_rd | req_wr;

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        resp      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                stall = req;
                if (req) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (wait_cnt == '0) begin
                    commit    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // Request lines still show the completed access here; ignore them.
                resp      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!reset) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wr     <= 1'b0;
            rdata      <= '0;
            access_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_wr    <= req_wr;
                        wait_cnt  <= WAIT_LD;
                    end
                end
                BUSY: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
            // Simultaneous read+write was latched as a store, so rdata is left alone.
            if (commit) begin
                if (lat_wr) begin
                    mem[lat_addr] <= lat_wdata;
                end else begin
                    rdata <= mem[lat_addr];
                end
            end
            if (resp && access_cnt != CNT_MAX) begin
                access_cnt <= access_cnt + CNT_W'(1);
            end
        end
    end

endmodule
